// File: rtl/wb_regfile_mw_if.sv
`default_nettype none
// ============================================================================
// Module   : wb_regfile_mw_if
// Purpose  : Multi-lane writeback bus between the EX/WB latches and the
//            register file.
// Revision : 1.0
// ============================================================================
interface wb_regfile_mw_if #(
    parameter int NUM_LANES = 2,
    parameter int RIDX_W    = 4,
    parameter int DATA_W    = 64
);
    logic [NUM_LANES-1:0]        wb_valid;
    logic                        wb_ready;
    logic [NUM_LANES-1:0]        wb_we;
    logic [NUM_LANES*RIDX_W-1:0] wb_dst;
    logic [NUM_LANES*DATA_W-1:0] wb_data;
    logic [NUM_LANES-1:0]        wb_ext_we;
    logic [NUM_LANES*RIDX_W-1:0] wb_ext_dst;
    logic [NUM_LANES*DATA_W-1:0] wb_ext_data;
    logic [NUM_LANES*2-1:0]      wb_sp_op;
    logic [NUM_LANES-1:0]        wb_store;
    logic [NUM_LANES-1:0]        wb_sim_end;

    modport master (
        output wb_valid, wb_we, wb_dst, wb_data, wb_ext_we, wb_ext_dst,
               wb_ext_data, wb_sp_op, wb_store, wb_sim_end,
        input  wb_ready
    );

    modport slave (
        input  wb_valid, wb_we, wb_dst, wb_data, wb_ext_we, wb_ext_dst,
               wb_ext_data, wb_sp_op, wb_store, wb_sim_end,
        output wb_ready
    );
endinterface
`default_nettype wire

// File: rtl/wb_regfile_mw.sv
`default_nettype none
// ============================================================================
// Module   : wb_regfile_mw
// Purpose  : Multi-lane writeback stage, register file with bypassed reads
//            and per-register pending-write scoreboard.
// Revision : 1.0
// ============================================================================
module wb_regfile_mw #(
    parameter  int NUM_REGS  = 16,
    parameter  int DATA_W    = 64,
    parameter  int NUM_LANES = 2,
    parameter  int NUM_RD    = 3,
    parameter  int SP_IDX    = 4,
    parameter  int SP_STEP   = 8,
    parameter  int CNT_W     = 2,
    localparam int RIDX_W    = $clog2(NUM_REGS)
) (
    input  wire logic                       clk,
    input  wire logic                       reset_n,
    wb_regfile_mw_if.slave                  wb,
    input  wire logic                       iss_valid,
    input  wire logic [NUM_REGS-1:0]        iss_mask,
    output logic                            iss_ready,
    input  wire logic [NUM_RD*RIDX_W-1:0]   rd_idx,
    output logic [NUM_RD*DATA_W-1:0]        rd_data,
    output logic [NUM_RD-1:0]               rd_busy,
    output logic [NUM_REGS*DATA_W-1:0]      regfile_flat,
    output logic [NUM_REGS-1:0]             pending,
    output logic [NUM_LANES-1:0]            store_done,
    output logic                            halted,
    output logic                            sb_err
);
    localparam int c_DEC_W = $clog2(3*NUM_LANES + 1);
    localparam int c_SUM_W = CNT_W + c_DEC_W + 1;
    localparam logic [CNT_W-1:0]   c_CNT_MAX = '1;
    localparam logic [DATA_W-1:0]  c_SP_STEP = DATA_W'(SP_STEP);
    localparam logic [c_DEC_W-1:0] c_DEC_ONE = c_DEC_W'(1);

    logic [DATA_W-1:0]    r_rf [NUM_REGS];
    logic [CNT_W-1:0]     r_cnt [NUM_REGS];
    logic                 r_halted;
    logic                 r_sb_err;
    logic [NUM_LANES-1:0] r_store_done;

    logic [DATA_W-1:0]    w_next_rf [NUM_REGS];
    logic [c_DEC_W-1:0]   w_dec [NUM_REGS];
    logic [CNT_W-1:0]     w_next_cnt [NUM_REGS];
    logic [NUM_LANES-1:0] w_acc;
    logic [NUM_REGS-1:0]  w_full;
    logic [NUM_REGS-1:0]  w_inc;
    logic [NUM_REGS-1:0]  w_under;
    logic [NUM_REGS-1:0]  w_busy;
    logic                 w_wb_ready;

    assign w_wb_ready  = !r_halted;
    assign wb.wb_ready = w_wb_ready;
    assign w_acc       = wb.wb_valid & {NUM_LANES{w_wb_ready}};

    // Lanes applied in ascending order, each as sp_op -> primary -> secondary,
    // so later writes naturally override and SP adjustments accumulate.
    always_comb begin
        w_next_rf = r_rf;
        for (int r = 0; r < NUM_REGS; r++) begin
            w_dec[r] = '0;
        end
        for (int l = 0; l < NUM_LANES; l++) begin
            if (w_acc[l]) begin
                if (wb.wb_sp_op[2*l +: 2] == 2'b01) begin
                    w_next_rf[SP_IDX] = w_next_rf[SP_IDX] + c_SP_STEP;
                    w_dec[SP_IDX]     = w_dec[SP_IDX] + c_DEC_ONE;
                end else if (wb.wb_sp_op[2*l +: 2] == 2'b10) begin
                    w_next_rf[SP_IDX] = w_next_rf[SP_IDX] - c_SP_STEP;
                    w_dec[SP_IDX]     = w_dec[SP_IDX] + c_DEC_ONE;
                end
                if (wb.wb_we[l]) begin
                    w_next_rf[wb.wb_dst[l*RIDX_W +: RIDX_W]] = wb.wb_data[l*DATA_W +: DATA_W];
                    w_dec[wb.wb_dst[l*RIDX_W +: RIDX_W]] =
                        w_dec[wb.wb_dst[l*RIDX_W +: RIDX_W]] + c_DEC_ONE;
                end
                if (wb.wb_ext_we[l]) begin
                    w_next_rf[wb.wb_ext_dst[l*RIDX_W +: RIDX_W]] = wb.wb_ext_data[l*DATA_W +: DATA_W];
                    w_dec[wb.wb_ext_dst[l*RIDX_W +: RIDX_W]] =
                        w_dec[wb.wb_ext_dst[l*RIDX_W +: RIDX_W]] + c_DEC_ONE;
                end
            end
        end
    end

    assign iss_ready = ~|w_full;

    for (genvar r = 0; r < NUM_REGS; r++) begin : g_reg
        logic [c_SUM_W-1:0] w_cur;
        logic [c_SUM_W-1:0] w_sum;
        logic [c_SUM_W-1:0] w_dec_ext;

        assign w_full[r]  = iss_mask[r] && (r_cnt[r] == c_CNT_MAX);
        assign w_inc[r]   = iss_valid && iss_ready && iss_mask[r];
        assign w_cur      = c_SUM_W'(r_cnt[r]);
        assign w_dec_ext  = c_SUM_W'(w_dec[r]);
        // Wide arithmetic so an over-decrement is detected rather than wrapped.
        assign w_sum      = w_cur + c_SUM_W'(w_inc[r]);
        assign w_under[r] = w_sum < w_dec_ext;
        assign w_next_cnt[r] = w_under[r] ? '0 : CNT_W'(w_sum - w_dec_ext);
        assign w_busy[r]  = (w_cur - w_dec_ext) != '0;
        assign pending[r] = r_cnt[r] != '0;
        assign regfile_flat[r*DATA_W +: DATA_W] = r_rf[r];
    end

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [RIDX_W-1:0] w_idx;

        assign w_idx = rd_idx[k*RIDX_W +: RIDX_W];
        assign rd_data[k*DATA_W +: DATA_W] = w_next_rf[w_idx];
        assign rd_busy[k] = w_busy[w_idx];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rf         <= '{default: '0};
            r_cnt        <= '{default: '0};
            r_halted     <= 1'b0;
            r_sb_err     <= 1'b0;
            r_store_done <= '0;
        end else begin
            r_rf         <= w_next_rf;
            r_cnt        <= w_next_cnt;
            r_halted     <= r_halted | (|(w_acc & wb.wb_sim_end));
            r_sb_err     <= r_sb_err | (|w_under);
            r_store_done <= w_acc & wb.wb_store;
        end
    end

    assign store_done = r_store_done;
    assign halted     = r_halted;
    assign sb_err     = r_sb_err;

endmodule
`default_nettype wire

// File: tb/tb_wb_regfile_mw.sv
`default_nettype none
// ============================================================================
// Module   : tb_wb_regfile_mw
// Purpose  : Self-checking bench for wb_regfile_mw against an array model.
// Revision : 1.0
// ============================================================================
module tb_wb_regfile_mw;
    logic          clk = 1'b0;
    logic          reset_n;
    logic          iss_valid;
    logic [15:0]   iss_mask;
    logic          iss_ready;
    logic [11:0]   rd_idx;
    logic [191:0]  rd_data;
    logic [2:0]    rd_busy;
    logic [1023:0] regfile_flat;
    logic [15:0]   pending;
    logic [1:0]    store_done;
    logic          halted;
    logic          sb_err;

    wb_regfile_mw_if #(.NUM_LANES(2), .RIDX_W(4), .DATA_W(64)) bus ();

    wb_regfile_mw dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .wb           (bus),
        .iss_valid    (iss_valid),
        .iss_mask     (iss_mask),
        .iss_ready    (iss_ready),
        .rd_idx       (rd_idx),
        .rd_data      (rd_data),
        .rd_busy      (rd_busy),
        .regfile_flat (regfile_flat),
        .pending      (pending),
        .store_done   (store_done),
        .halted       (halted),
        .sb_err       (sb_err)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic [63:0] m_rf [16];
    int          m_cnt [16];
    bit          m_halt;
    bit          m_err;

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int r = 0; r < 16; r++) begin
            m_rf[r]  = 64'h0;
            m_cnt[r] = 0;
        end
        m_halt = 1'b0;
        m_err  = 1'b0;
    endtask

    task automatic idle();
        bus.wb_valid = '0; bus.wb_we = '0; bus.wb_dst = '0; bus.wb_data = '0;
        bus.wb_ext_we = '0; bus.wb_ext_dst = '0; bus.wb_ext_data = '0;
        bus.wb_sp_op = '0; bus.wb_store = '0; bus.wb_sim_end = '0;
        iss_valid = 1'b0; iss_mask = '0; rd_idx = '0;
    endtask

    task automatic set_lane(int l, bit we, int dst, logic [63:0] data, bit ext_we, int ext_dst,
                            logic [63:0] ext_data, logic [1:0] sp, bit st, bit se);
        bus.wb_valid[l]           = 1'b1;
        bus.wb_we[l]              = we;
        bus.wb_dst[4*l +: 4]      = 4'(dst);
        bus.wb_data[64*l +: 64]   = data;
        bus.wb_ext_we[l]          = ext_we;
        bus.wb_ext_dst[4*l +: 4]  = 4'(ext_dst);
        bus.wb_ext_data[64*l +: 64] = ext_data;
        bus.wb_sp_op[2*l +: 2]    = sp;
        bus.wb_store[l]           = st;
        bus.wb_sim_end[l]         = se;
    endtask

    task automatic check_state(logic [1:0] exp_sd);
        logic [15:0] exp_pend;
        for (int r = 0; r < 16; r++) begin
            chk($sformatf("regfile[%0d]", r), regfile_flat[64*r +: 64], m_rf[r]);
            exp_pend[r] = (m_cnt[r] != 0);
        end
        chk("pending", 64'(pending), 64'(exp_pend));
        chk("halted", 64'(halted), 64'(m_halt));
        chk("sb_err", 64'(sb_err), 64'(m_err));
        chk("store_done", 64'(store_done), 64'(exp_sd));
    endtask

    // One clock: predict from spec rules, check combinational outputs before
    // the edge and registered state after it.
    task automatic cycle();
        logic [63:0] nrf [16];
        int          dec [16];
        int          ncnt [16];
        bit          rdy, nerr, nhalt;
        logic [1:0]  acc, exp_sd;
        int          d, idx;
        @(negedge clk);
        nrf = m_rf;
        for (int r = 0; r < 16; r++) dec[r] = 0;
        acc = m_halt ? 2'b00 : bus.wb_valid;
        for (int l = 0; l < 2; l++) begin
            if (acc[l]) begin
                case (bus.wb_sp_op[2*l +: 2])
                    2'b01: begin nrf[4] = nrf[4] + 64'd8; dec[4]++; end
                    2'b10: begin nrf[4] = nrf[4] - 64'd8; dec[4]++; end
                    default: ;
                endcase
                if (bus.wb_we[l]) begin
                    d = int'(bus.wb_dst[4*l +: 4]);
                    nrf[d] = bus.wb_data[64*l +: 64];
                    dec[d]++;
                end
                if (bus.wb_ext_we[l]) begin
                    d = int'(bus.wb_ext_dst[4*l +: 4]);
                    nrf[d] = bus.wb_ext_data[64*l +: 64];
                    dec[d]++;
                end
            end
        end
        rdy = 1'b1;
        for (int r = 0; r < 16; r++)
            if (iss_mask[r] && m_cnt[r] >= 3) rdy = 1'b0;
        chk("iss_ready", 64'(iss_ready), 64'(rdy));
        chk("wb_ready", 64'(bus.wb_ready), 64'(!m_halt));
        for (int k = 0; k < 3; k++) begin
            idx = int'(rd_idx[4*k +: 4]);
            chk($sformatf("rd_data[%0d]", k), rd_data[64*k +: 64], nrf[idx]);
            chk($sformatf("rd_busy[%0d]", k), 64'(rd_busy[k]), 64'((m_cnt[idx] - dec[idx]) != 0));
        end
        nerr = m_err;
        for (int r = 0; r < 16; r++) begin
            ncnt[r] = m_cnt[r] + ((iss_valid && rdy && iss_mask[r]) ? 1 : 0) - dec[r];
            if (ncnt[r] < 0) begin
                ncnt[r] = 0;
                nerr = 1'b1;
            end
        end
        nhalt  = m_halt | (|(acc & bus.wb_sim_end));
        exp_sd = acc & bus.wb_store;
        @(posedge clk);
        #1;
        m_rf = nrf; m_cnt = ncnt; m_err = nerr; m_halt = nhalt;
        check_state(exp_sd);
    endtask

    task automatic issue(logic [15:0] mask);
        idle();
        iss_valid = 1'b1;
        iss_mask  = mask;
        cycle();
    endtask

    initial begin
        reset_n = 1'b0;
        idle();
        model_reset();
        #12;
        check_state(2'b00);
        chk("reset wb_ready", 64'(bus.wb_ready), 64'd1);
        chk("reset iss_ready", 64'(iss_ready), 64'd1);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        // Basic write with same-cycle bypass
        idle(); iss_valid = 1'b1; iss_mask = 16'h0008; rd_idx = 12'h003;
        set_lane(0, 1, 3, 64'h1234, 0, 0, 64'h0, 2'b00, 0, 0);
        cycle();
        chk("R3", regfile_flat[64*3 +: 64], 64'h1234);

        // SP accumulation and override
        idle(); iss_valid = 1'b1; iss_mask = 16'h0010;
        set_lane(0, 1, 4, 64'h1000, 0, 0, 64'h0, 2'b00, 0, 0);
        cycle();
        issue(16'h0010); issue(16'h0010);
        idle(); rd_idx = 12'h004;
        set_lane(0, 0, 0, 64'h0, 0, 0, 64'h0, 2'b10, 0, 0);
        set_lane(1, 0, 0, 64'h0, 0, 0, 64'h0, 2'b10, 0, 0);
        cycle();
        chk("SP-16", regfile_flat[64*4 +: 64], 64'h0FF0);
        issue(16'h0010); issue(16'h0010);
        idle(); rd_idx = 12'h004;
        set_lane(0, 0, 0, 64'h0, 0, 0, 64'h0, 2'b10, 0, 0);
        set_lane(1, 1, 4, 64'h5000, 0, 0, 64'h0, 2'b00, 0, 0);
        cycle();
        chk("SP override", regfile_flat[64*4 +: 64], 64'h5000);

        // Cross-lane override with secondary destination
        issue(16'h0001);
        idle(); iss_valid = 1'b1; iss_mask = 16'h0005; rd_idx = 12'h020;
        set_lane(0, 1, 0, 64'h1, 1, 2, 64'h2, 2'b00, 0, 0);
        set_lane(1, 1, 0, 64'h7, 0, 0, 64'h0, 2'b00, 0, 0);
        cycle();
        chk("R0", regfile_flat[64*0 +: 64], 64'h7);
        chk("R2", regfile_flat[64*2 +: 64], 64'h2);
        chk("no underflow yet", 64'(sb_err), 64'd0);

        // Scoreboard saturation and underflow
        issue(16'h0020); issue(16'h0020); issue(16'h0020);
        idle(); iss_valid = 1'b1; iss_mask = 16'h0020;
        #1;
        chk("iss_ready full", 64'(iss_ready), 64'd0);
        cycle();
        chk("pending R5 full", 64'(pending[5]), 64'd1);
        idle(); iss_valid = 1'b1; iss_mask = 16'h0020; rd_idx = 12'h005;
        set_lane(0, 1, 5, 64'h55, 0, 0, 64'h0, 2'b00, 0, 0);
        #1;
        chk("rd_busy R5", 64'(rd_busy[0]), 64'd1);
        chk("iss_ready full+wb", 64'(iss_ready), 64'd0);
        cycle();
        idle(); iss_valid = 1'b1; iss_mask = 16'h0020; rd_idx = 12'h005;
        set_lane(0, 1, 5, 64'h56, 0, 0, 64'h0, 2'b00, 0, 0);
        cycle();
        idle();
        set_lane(0, 1, 5, 64'h57, 0, 0, 64'h0, 2'b00, 0, 0);
        set_lane(1, 1, 5, 64'h58, 0, 0, 64'h0, 2'b00, 0, 0);
        cycle();
        chk("pending R5 drained", 64'(pending[5]), 64'd0);
        chk("sb_err before", 64'(sb_err), 64'd0);
        idle();
        set_lane(0, 1, 5, 64'h59, 0, 0, 64'h0, 2'b00, 0, 0);
        cycle();
        chk("sb_err underflow", 64'(sb_err), 64'd1);

        // Store pulse with SP decrement
        issue(16'h0010);
        idle();
        set_lane(1, 0, 0, 64'h0, 0, 0, 64'h0, 2'b10, 1, 0);
        cycle();
        chk("store_done pulse", 64'(store_done), 64'h2);
        chk("SP after store", regfile_flat[64*4 +: 64], 64'h4FF8);
        idle();
        cycle();
        chk("store_done clear", 64'(store_done), 64'h0);

        // Random traffic
        for (int n = 0; n < 200; n++) begin
            idle();
            iss_valid = 1'($urandom_range(0, 1));
            iss_mask[$urandom_range(0, 15)] = 1'b1;
            if ($urandom_range(0, 3) == 0) iss_mask[$urandom_range(0, 15)] = 1'b1;
            rd_idx = 12'($urandom);
            for (int l = 0; l < 2; l++) begin
                if ($urandom_range(0, 3) != 0)
                    set_lane(l, 1'($urandom_range(0, 1)), int'($urandom_range(0, 15)), {$urandom, $urandom},
                             ($urandom_range(0, 3) == 0), int'($urandom_range(0, 15)), {$urandom, $urandom},
                             2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'b0);
            end
            cycle();
        end

        // Simulation end: beat still commits, later beats ignored
        idle(); rd_idx = 12'h001;
        set_lane(0, 1, 1, 64'h9, 0, 0, 64'h0, 2'b00, 0, 1);
        set_lane(1, 1, 6, 64'h66, 0, 0, 64'h0, 2'b00, 0, 0);
        cycle();
        chk("R1 at halt", regfile_flat[64*1 +: 64], 64'h9);
        chk("halted", 64'(halted), 64'd1);
        chk("wb_ready halted", 64'(bus.wb_ready), 64'd0);
        idle(); rd_idx = 12'h001; iss_valid = 1'b1; iss_mask = 16'h0080;
        set_lane(0, 1, 1, 64'h5, 0, 0, 64'h0, 2'b01, 1, 0);
        cycle();
        chk("R1 ignored", regfile_flat[64*1 +: 64], 64'h9);

        // Asynchronous reset in the middle of a beat
        idle();
        set_lane(0, 1, 8, 64'hAB, 0, 0, 64'h0, 2'b00, 1, 0);
        #2;
        reset_n = 1'b0;
        #1;
        model_reset();
        check_state(2'b00);
        chk("mid-reset wb_ready", 64'(bus.wb_ready), 64'd1);
        @(posedge clk);
        #1;
        chk("dropped R8", regfile_flat[64*8 +: 64], 64'h0);
        chk("dropped store", 64'(store_done), 64'h0);
        idle();
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        idle(); iss_valid = 1'b1; iss_mask = 16'h0200; rd_idx = 12'h009;
        set_lane(0, 1, 9, 64'hC0FFEE, 0, 0, 64'h0, 2'b00, 0, 0);
        cycle();
        chk("R9 after reset", regfile_flat[64*9 +: 64], 64'hC0FFEE);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire
